// File: rtl/vlm_if.sv
// VLM link bundle: command enable/direction, device hold, packed argument and result buses.
// Handshake: the master presents a command with en=1 (we selects write/read) and its args;
// the device stalls it with hold=1. The command completes in any cycle with en=1 and hold=0.
// While hold is high the master keeps en, we and the relevant args unchanged.
interface vlm_if #(
  parameter int RA_W = 32,
  parameter int WA_W = 64,
  parameter int RR_W = 32
) ();
  logic            en;
  logic            we;
  logic            hold;
  logic [RA_W-1:0] read_args;
  logic [WA_W-1:0] write_args;
  logic [RR_W-1:0] read_results;

  modport master (
    output en, we, read_args, write_args,
    input  hold, read_results
  );

  modport slave (
    input  en, we, read_args, write_args,
    output hold, read_results
  );

  modport monitor (
    input en, we, hold, read_args, write_args, read_results
  );
endinterface

// File: rtl/vlm_protocol_monitor.sv
// Passive VLM link checker: sticky per-class violation flags, first-error capture, hold timeout
// and saturating read/write counters. Define VLM_MON_OUTPUT_CHECK_EN to enable the read_results stability check.
module vlm_protocol_monitor #(
  parameter int RA_W     = 32,
  parameter int WA_W     = 64,
  parameter int RR_W     = 32,
  parameter int CNT_W    = 16,
  parameter int MAX_HOLD = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  vlm_if.monitor           bus,
  input  logic             clr,
  output logic             err_pulse,
  output logic [6:0]       err_flags,
  output logic [2:0]       first_code,
  output logic [CNT_W-1:0] first_cycle,
  output logic             first_valid,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam int HC_W      = $clog2(MAX_HOLD + 2);
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  logic            en;
  logic            we;
  logic            hold;
  logic [RA_W-1:0] ra;
  logic [WA_W-1:0] wa;
  logic [RR_W-1:0] rr;

  assign en   = bus.en;
  assign we   = bus.we;
  assign hold = bus.hold;
  assign ra   = bus.read_args;
  assign wa   = bus.write_args;
  assign rr   = bus.read_results;

  logic            hist_valid;
  logic            prev_en;
  logic            prev_we;
  logic            prev_hold;
  logic [RA_W-1:0] prev_ra;
  logic [WA_W-1:0] prev_wa;
`ifdef VLM_MON_OUTPUT_CHECK_EN
  logic [RR_W-1:0] prev_rr;
  logic            prev_rd_cpl;
`endif

  logic [HC_W-1:0]  hold_cnt;
  logic [CNT_W-1:0] cycle_cnt;

  logic             busy_hold;
  logic             rd_cpl;
  logic             wr_cpl;
  logic             timeout_hit;
  logic [6:0]       viol_raw;
  logic [6:0]       viol;
  logic [2:0]       viol_idx;
  logic [CNT_W-1:0] rd_base;
  logic [CNT_W-1:0] wr_base;
  logic [CNT_W-1:0] rd_next;
  logic [CNT_W-1:0] wr_next;

  assign busy_hold = en & hold;
  assign rd_cpl    = en & ~hold & ~we;
  assign wr_cpl    = en & ~hold & we;

  // hold_cnt counts completed hold cycles of the current command; the MAX_HOLD-th one trips the timeout.
  assign timeout_hit = (MAX_HOLD != 0) && busy_hold && (hold_cnt == HC_W'(HOLD_LAST));

  always_comb begin
    viol_raw = '0;
`ifndef SYNTHESIS
    // X/Z detection only has meaning in a 4-state simulator; synthesis sees constant 0.
    viol_raw[0] = ((^{en, hold}) === 1'bx) || (en && ((^we) === 1'bx));
    viol_raw[1] = (en && !we && ((^ra) === 1'bx)) ||
                  (en && we && ((^wa) === 1'bx)) ||
                  ((rd_count != '0) && ((^rr) === 1'bx));
`endif
    viol_raw[2] = hold & ~en;
    viol_raw[3] = hist_valid & prev_hold & ((en != prev_en) | (we != prev_we));
    viol_raw[4] = hist_valid & prev_hold & (prev_we ? (wa != prev_wa) : (ra != prev_ra));
`ifdef VLM_MON_OUTPUT_CHECK_EN
    viol_raw[5] = hist_valid & ~prev_rd_cpl & (rr != prev_rr);
`endif
    viol_raw[6] = timeout_hit;

    viol = viol_raw;
    if (viol_raw[0]) viol[5:1] = '0;
  end

  always_comb begin
    viol_idx = '0;
    for (int i = 6; i >= 0; i--) begin
      if (viol[i]) viol_idx = 3'(i);
    end
  end

  // A clear and a same-cycle completion still leave that completion counted.
  always_comb begin
    rd_base = clr ? '0 : rd_count;
    wr_base = clr ? '0 : wr_count;
    rd_next = rd_base;
    wr_next = wr_base;
    if (rd_cpl && (rd_base != '1)) rd_next = rd_base + 1'b1;
    if (wr_cpl && (wr_base != '1)) wr_next = wr_base + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_valid  <= 1'b0;
      prev_en     <= 1'b0;
      prev_we     <= 1'b0;
      prev_hold   <= 1'b0;
      prev_ra     <= '0;
      prev_wa     <= '0;
`ifdef VLM_MON_OUTPUT_CHECK_EN
      prev_rr     <= '0;
      prev_rd_cpl <= 1'b0;
`endif
      hold_cnt    <= '0;
      cycle_cnt   <= '0;
      err_pulse   <= 1'b0;
      err_flags   <= '0;
      first_code  <= '0;
      first_cycle <= '0;
      first_valid <= 1'b0;
      rd_count    <= '0;
      wr_count    <= '0;
    end else begin
      hist_valid  <= ~clr;
      prev_en     <= en;
      prev_we     <= we;
      prev_hold   <= hold;
      prev_ra     <= ra;
      prev_wa     <= wa;
`ifdef VLM_MON_OUTPUT_CHECK_EN
      prev_rr     <= rr;
      prev_rd_cpl <= rd_cpl;
`endif

      // Saturating at MAX_HOLD keeps the timeout from refiring while the same hold continues.
      if (!busy_hold) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HC_W'(MAX_HOLD)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end

      if (clr) begin
        cycle_cnt <= '0;
      end else if (cycle_cnt != '1) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end

      err_pulse <= |viol;
      err_flags <= (clr ? 7'b0 : err_flags) | viol;
      rd_count  <= rd_next;
      wr_count  <= wr_next;

      if ((|viol) && (clr || !first_valid)) begin
        first_code  <= viol_idx;
        first_cycle <= cycle_cnt;
        first_valid <= 1'b1;
      end else if (clr) begin
        first_code  <= '0;
        first_cycle <= '0;
        first_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vlm_protocol_monitor.sv
// Directed bench for vlm_protocol_monitor with hand-computed expectations per scenario.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_vlm_protocol_monitor;

  localparam int RA_W     = 32;
  localparam int WA_W     = 64;
  localparam int RR_W     = 32;
  localparam int CNT_W    = 16;
  localparam int MAX_HOLD = 4;

`ifdef VLM_MON_OUTPUT_CHECK_EN
  localparam logic [6:0] EXP_C5 = 7'h20;
`else
  localparam logic [6:0] EXP_C5 = 7'h00;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  always #5 clk = ~clk;

  logic             err_pulse;
  logic [6:0]       err_flags;
  logic [2:0]       first_code;
  logic [CNT_W-1:0] first_cycle;
  logic             first_valid;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;

  int n_checks = 0;
  int n_errors = 0;

  // expected {err_pulse, err_flags} per cycle for the timeout scenario
  logic [7:0] exp_q[$];

  vlm_if #(.RA_W(RA_W), .WA_W(WA_W), .RR_W(RR_W)) bus ();

  vlm_protocol_monitor #(
    .RA_W(RA_W), .WA_W(WA_W), .RR_W(RR_W), .CNT_W(CNT_W), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .clr         (clr),
    .err_pulse   (err_pulse),
    .err_flags   (err_flags),
    .first_code  (first_code),
    .first_cycle (first_cycle),
    .first_valid (first_valid),
    .rd_count    (rd_count),
    .wr_count    (wr_count)
  );

  // scoreboard compare
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic we, input logic hold);
    bus.en   = en;
    bus.we   = we;
    bus.hold = hold;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr   = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    bus.read_args    = '0;
    bus.write_args   = '0;
    bus.read_results = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pulse"}, 64'(err_pulse), 0);
    check_eq({tag, "_flags"}, 64'(err_flags), 0);
    check_eq({tag, "_fvalid"}, 64'(first_valid), 0);
    check_eq({tag, "_fcode"}, 64'(first_code), 0);
    check_eq({tag, "_fcycle"}, 64'(first_cycle), 0);
    check_eq({tag, "_rd"}, 64'(rd_count), 0);
    check_eq({tag, "_wr"}, 64'(wr_count), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_v;
    int         pulses;

    // reset state
    do_reset();
    check_all_zero("reset");

    // read held 3 cycles with stable args, then completion
    bus.read_args = 32'h1234_5678;
    drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rd_hold_pulse", 64'(err_pulse), 0);
    end
    drive(1'b1, 1'b0, 1'b0);
    tick();
    check_eq("rd_cpl_pulse", 64'(err_pulse), 0);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check_eq("rd_cpl_count", 64'(rd_count), 1);
    check_eq("rd_cpl_wr", 64'(wr_count), 0);
    check_eq("rd_cpl_flags", 64'(err_flags), 0);

    // hold without en at cycle 5
    do_reset();
    repeat (5) tick();
    drive(1'b0, 1'b0, 1'b1);
    tick();
    check_eq("orphan_pulse", 64'(err_pulse), 1);
    check_eq("orphan_flags", 64'(err_flags), 64'h04);
    check_eq("orphan_code", 64'(first_code), 2);
    check_eq("orphan_cycle", 64'(first_cycle), 5);
    check_eq("orphan_valid", 64'(first_valid), 1);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check_eq("orphan_pulse_end", 64'(err_pulse), 0);

    // write hold: args change and we flip in the same cycle
    do_reset();
    bus.write_args = 64'h0000_0001_0000_0010;
    drive(1'b1, 1'b1, 1'b1);
    tick();
    tick();
    check_eq("wr_hold_pulse", 64'(err_pulse), 0);
    bus.write_args = 64'h0000_0001_0000_0014;
    drive(1'b1, 1'b0, 1'b1);
    tick();
    check_eq("chg_pulse", 64'(err_pulse), 1);
    check_eq("chg_flags", 64'(err_flags), 64'h18);
    check_eq("chg_code", 64'(first_code), 3);
    check_eq("chg_cycle", 64'(first_cycle), 2);
    drive(1'b1, 1'b0, 1'b0);
    tick();
    check_eq("chg_cpl_pulse", 64'(err_pulse), 0);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check_eq("chg_flags_kept", 64'(err_flags), 64'h18);
    check_eq("chg_rd", 64'(rd_count), 1);

    // hold timeout with MAX_HOLD=4, held for 10 cycles
    do_reset();
    bus.read_args = 32'hCAFE_0001;
    drive(1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      exp_q.push_back({(i == 4) ? 1'b1 : 1'b0, (i >= 4) ? 7'h40 : 7'h00});
    end
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      if (err_pulse === 1'b1) pulses++;
      check_eq($sformatf("tmo_c%0d", i), 64'({err_pulse, err_flags}), 64'(exp_v));
    end
    check_eq("tmo_pulses", 64'(pulses), 1);
    check_eq("tmo_code", 64'(first_code), 6);
    check_eq("tmo_cycle", 64'(first_cycle), 3);
    rst_n = 1'b0;
    #2;
    check_all_zero("midrst");

    // read_results stability, with and without a preceding completion
    do_reset();
    bus.read_results = 32'h0000_AAAA;
    tick();
    drive(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    bus.read_results = 32'h0000_5555;
    tick();
    tick();
    check_eq("rr_after_cpl", 64'(err_flags), 0);
    check_eq("rr_rd", 64'(rd_count), 1);
    bus.read_results = 32'h0000_AAAA;
    tick();
    check_eq("rr_change_flags", 64'(err_flags), 64'(EXP_C5));
    check_eq("rr_change_pulse", 64'(err_pulse), (EXP_C5 != 0) ? 1 : 0);

    // clear, then violation coinciding with clear, then write saturation
    do_reset();
    tick();
    drive(1'b0, 1'b0, 1'b1);
    tick();
    check_eq("pre_clr_flags", 64'(err_flags), 64'h04);
    drive(1'b0, 1'b0, 1'b0);
    clr = 1'b1;
    tick();
    check_eq("clr_flags", 64'(err_flags), 0);
    check_eq("clr_valid", 64'(first_valid), 0);
    drive(1'b0, 1'b0, 1'b1);
    tick();
    clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check_eq("clr_same_flags", 64'(err_flags), 64'h04);
    check_eq("clr_same_valid", 64'(first_valid), 1);
    check_eq("clr_same_code", 64'(first_code), 2);
    check_eq("clr_same_cycle", 64'(first_cycle), 0);
    bus.write_args = 64'h0123_4567_89AB_CDEF;
    drive(1'b1, 1'b1, 1'b0);
    repeat (65534) tick();
    check_eq("wr_near_sat", 64'(wr_count), 64'hFFFE);
    repeat (70000 - 65534) tick();
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check_eq("wr_sat", 64'(wr_count), 64'hFFFF);
    check_eq("wr_sat_rd", 64'(rd_count), 0);
    check_eq("wr_sat_flags", 64'(err_flags), 64'h04);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
